// File: rtl/gray2bin_pkg.sv
// gray2bin_pkg: symbol-width helper and bundle types
// shared by the gray2bin scheduler and its bench.
package gray2bin_pkg;

  function automatic int sym_w(input int order);
    return (order > 2) ? $clog2(order) : 1;
  endfunction

  localparam int MOD_ORDER = 16;
  localparam int N_CH_DEF  = 4;
  localparam int W_DEF     = sym_w(MOD_ORDER);
  localparam int CW_DEF    = $clog2(N_CH_DEF);

  typedef struct packed {
    logic              vld;
    logic [CW_DEF-1:0] ch;
  } tag_t;

  typedef struct packed {
    logic [W_DEF-1:0]  binary;
    logic [CW_DEF-1:0] ch;
  } fifo_word_t;

endpackage

// File: rtl/gray2bin_sched_if.sv
// gray2bin_sched_if: requester, converter and result
// buses of the shared gray2bin scheduler.
interface gray2bin_sched_if #(
  parameter int W    = gray2bin_pkg::sym_w(16),
  parameter int N_CH = 4,
  parameter int CW   = $clog2(N_CH)
);

  logic [N_CH-1:0]        req_valid;
  logic [N_CH-1:0][W-1:0] req_gray;
  logic [N_CH-1:0]        req_ready;

  logic [W-1:0]           g2b_gray;
  logic                   g2b_i_dv;
  logic [W-1:0]           g2b_binary;
  logic                   g2b_o_dv;

  logic                   out_valid;
  logic                   out_ready;
  logic [W-1:0]           out_binary;
  logic [CW-1:0]          out_ch;
  logic                   sched_err;

  modport master (
    output req_valid,
    output req_gray,
    input  req_ready,
    input  g2b_gray,
    input  g2b_i_dv,
    output g2b_binary,
    output g2b_o_dv,
    input  out_valid,
    output out_ready,
    input  out_binary,
    input  out_ch,
    input  sched_err
  );

  modport slave (
    input  req_valid,
    input  req_gray,
    output req_ready,
    output g2b_gray,
    output g2b_i_dv,
    input  g2b_binary,
    input  g2b_o_dv,
    output out_valid,
    input  out_ready,
    output out_binary,
    output out_ch,
    output sched_err
  );

endinterface

// File: rtl/gray2bin_sched_fifo.sv
// gray2bin_sched_fifo: synchronous FIFO whose head word
// sits in an output register (registered read).
module gray2bin_sched_fifo
  import gray2bin_pkg::*;
#(
  parameter int DW    = 6,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DW-1:0]          wdata,
  input  logic                   rd_ready,
  output logic                   rvalid,
  output logic [DW-1:0]          rdata,
  output logic                   pop,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CNW = AW + 1;

  logic [DW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  rd_q, rd_d;
  logic [AW-1:0]  wr_q, wr_d;
  logic [CNW-1:0] cnt_q, cnt_d;
  logic [CNW-1:0] rem;
  logic           vld_q, vld_d;
  logic [DW-1:0]  dat_q, dat_d;
  logic           wen;

  assign pop = vld_q && rd_ready;
  assign wen = push && ((cnt_q != CNW'(DEPTH)) || pop);

  // head register takes the new word when nothing older remains
  always_comb begin
    rd_d  = rd_q + AW'(pop);
    wr_d  = wr_q + AW'(wen);
    cnt_d = cnt_q + CNW'(wen) - CNW'(pop);
    rem   = cnt_q - CNW'(pop);
    vld_d = (cnt_d != '0);
    dat_d = dat_q;
    if (wen && (rem == '0)) begin
      dat_d = wdata;
    end else if (rem != '0) begin
      dat_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (wen) begin
      mem_q[wr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign rvalid = vld_q;
  assign rdata  = dat_q;
  assign count  = cnt_q;

endmodule

// File: rtl/gray2bin_sched.sv
// gray2bin_sched: round-robin issue of N_CH gray symbols into
// one gray2bin converter, tag realignment and output buffering.
module gray2bin_sched
  import gray2bin_pkg::*;
#(
  parameter int MODULATION_ORDER = 16,
  parameter int N_CH             = 4,
  parameter int G2B_LATENCY      = 1,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic            clk,
  input  logic            rst,
  gray2bin_sched_if.slave bus
);

  localparam int W   = sym_w(MODULATION_ORDER);
  localparam int CW  = $clog2(N_CH);
  localparam int NS  = G2B_LATENCY + 1;
  localparam int DW  = W + CW;
  localparam int CNW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic          vld;
    logic [CW-1:0] ch;
  } stag_t;

  typedef struct packed {
    logic [W-1:0]  binary;
    logic [CW-1:0] ch;
  } sword_t;

  logic [CW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]    gray_q, gray_d;
  logic            idv_q, idv_d;
  stag_t [NS-1:0]  tag_q, tag_d;
  logic            err_q, err_d;

  logic [N_CH-1:0] grant;
  logic [CW-1:0]   gnt_ch;
  logic [CW-1:0]   cand;
  logic            gnt_any;
  logic            found;
  logic            grant_ok;
  int              inflight;
  int              credits;

  stag_t           last;
  logic            push;
  sword_t          wword;
  sword_t          rword;
  logic            fifo_vld;
  logic            fifo_pop;
  logic [CNW-1:0]  fifo_cnt;

  // stage 0 rides with g2b_i_dv, the last stage with g2b_o_dv
  always_comb begin
    inflight = 0;
    for (int s = 0; s < NS; s++) begin
      inflight += int'(tag_q[s].vld);
    end
    credits  = FIFO_DEPTH - int'(fifo_cnt)
             + int'(fifo_pop) - inflight;
    grant_ok = !rst && (credits > 0);
  end

  always_comb begin
    grant  = '0;
    gnt_ch = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      cand = CW'((int'(ptr_q) + k) % N_CH);
      if (!found && grant_ok && bus.req_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        gnt_ch      = cand;
      end
    end
  end

  assign gnt_any = |grant;

  always_comb begin
    ptr_d    = ptr_q;
    gray_d   = gray_q;
    idv_d    = gnt_any;
    tag_d[0] = '{vld: gnt_any, ch: gnt_ch};
    for (int s = 1; s < NS; s++) begin
      tag_d[s] = tag_q[s-1];
    end
    if (gnt_any) begin
      gray_d = bus.req_gray[gnt_ch];
      if (int'(gnt_ch) == N_CH - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_ch + CW'(1);
      end
    end
  end

  assign last  = tag_q[NS-1];
  assign push  = last.vld && bus.g2b_o_dv;
  assign wword = '{binary: bus.g2b_binary, ch: last.ch};

  always_comb begin
    err_d = err_q || (last.vld != bus.g2b_o_dv);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      gray_q <= '0;
      idv_q  <= 1'b0;
      tag_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      gray_q <= gray_d;
      idv_q  <= idv_d;
      tag_q  <= tag_d;
      err_q  <= err_d;
    end
  end

  gray2bin_sched_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wdata    (wword),
    .rd_ready (bus.out_ready),
    .rvalid   (fifo_vld),
    .rdata    (rword),
    .pop      (fifo_pop),
    .count    (fifo_cnt)
  );

  assign bus.req_ready  = grant;
  assign bus.g2b_gray   = gray_q;
  assign bus.g2b_i_dv   = idv_q;
  assign bus.out_valid  = fifo_vld;
  assign bus.out_binary = rword.binary;
  assign bus.out_ch     = rword.ch;
  assign bus.sched_err  = err_q;

endmodule

// File: tb/tb_gray2bin_sched.sv
// tb_gray2bin_sched: scheduler with a one-cycle gray2bin model,
// vector table, corner sequences and a scoreboard.
`timescale 1ns/1ps
module tb_gray2bin_sched;
  import gray2bin_pkg::*;

  localparam int MO    = 16;
  localparam int NCH   = 4;
  localparam int LAT   = 1;
  localparam int DEPTH = 8;
  localparam int W     = sym_w(MO);
  localparam int CW    = $clog2(NCH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gray2bin_sched_if #(.W(W), .N_CH(NCH)) bus ();

  gray2bin_sched #(
    .MODULATION_ORDER (MO),
    .N_CH             (NCH),
    .G2B_LATENCY      (LAT),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [W-1:0] g2b_ref(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [W-1:0] g2b_shift(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  // converter model: not reset, like the real block
  logic         conv_dv  = 1'b0;
  logic [W-1:0] conv_bin = '0;
  logic         force_dv = 1'b0;
  always @(posedge clk) begin
    conv_dv  <= bus.g2b_i_dv;
    conv_bin <= g2b_shift(bus.g2b_gray);
  end
  assign bus.g2b_o_dv   = conv_dv | force_dv;
  assign bus.g2b_binary = conv_bin;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int pop_count = 0;
  int grant_log[$];
  fifo_word_t sb_q[$];
  fifo_word_t exp_w;
  int wait_cnt [NCH];
  logic prev_stall = 1'b0;
  logic [W-1:0] prev_bin;
  logic [CW-1:0] prev_ch;
  int gi;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst) begin
      sb_q.delete();
      prev_stall = 1'b0;
      for (int i = 0; i < NCH; i++) wait_cnt[i] = 0;
    end else begin
      chk("onehot", int'($countones(bus.req_ready) <= 1), 1);
      chk("grant_wo_valid", int'(bus.req_ready & ~bus.req_valid), 0);
      gi = -1;
      for (int i = 0; i < NCH; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          gi = i;
          sb_q.push_back('{binary: g2b_ref(bus.req_gray[i]), ch: CW'(i)});
          grant_log.push_back(i);
          hs_count++;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (!bus.req_valid[i] || i == gi) begin
          wait_cnt[i] = 0;
        end else if (gi >= 0) begin
          wait_cnt[i]++;
          chk("starve", int'(wait_cnt[i] <= NCH - 1), 1);
        end
      end
      if (prev_stall) begin
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_bin", int'(bus.out_binary), int'(prev_bin));
        chk("hold_ch", int'(bus.out_ch), int'(prev_ch));
      end
      if (bus.out_valid && bus.out_ready) begin
        pop_count++;
        if (sb_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          exp_w = sb_q.pop_front();
          chk("out_binary", int'(bus.out_binary), int'(exp_w.binary));
          chk("out_ch", int'(bus.out_ch), int'(exp_w.ch));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_bin   = bus.out_binary;
      prev_ch    = bus.out_ch;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    force_dv = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic [CW-1:0] ch;
    logic [W-1:0]  gray;
    logic [W-1:0]  bin;
  } vec_t;

  vec_t tbl [6];
  int   p0;
  int   h0;
  int   lat;
  bit   hs;

  initial begin
    tbl[0] = '{2'd2, 4'b1000, 4'b1111};
    tbl[1] = '{2'd0, 4'b0110, 4'b0100};
    tbl[2] = '{2'd1, 4'b0111, 4'b0101};
    tbl[3] = '{2'd3, 4'b1001, 4'b1110};
    tbl[4] = '{2'd1, 4'b1111, 4'b1010};
    tbl[5] = '{2'd0, 4'b0000, 4'b0000};

    bus.req_valid = '0;
    bus.req_gray  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_i_dv", int'(bus.g2b_i_dv), 0);
    chk("rst_g2b_gray", int'(bus.g2b_gray), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_binary", int'(bus.out_binary), 0);
    chk("rst_out_ch", int'(bus.out_ch), 0);
    chk("rst_sched_err", int'(bus.sched_err), 0);

    // all channels busy: RR order and one result per clock
    grant_log.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) bus.req_gray[i] = W'(6 + i);
    bus.req_valid = '1;
    bus.out_ready = 1'b1;
    idle(4);
    p0 = pop_count;
    idle(12);
    chk("t1_throughput", pop_count - p0, 12);
    for (int k = 0; k < 8; k++) chk("t1_order", grant_log[k], k % NCH);
    bus.req_valid = '0;
    idle(8);
    chk("t1_drained", sb_q.size(), 0);

    // single-channel vectors: latency and conversion
    for (int v = 0; v < 6; v++) begin
      hs  = 1'b0;
      lat = 0;
      @(posedge clk);
      #1;
      bus.req_gray[tbl[v].ch] = tbl[v].gray;
      bus.req_valid = NCH'(1) << tbl[v].ch;
      for (int k = 0; k < 20 && !hs; k++) begin
        @(negedge clk);
        hs = bus.req_ready[tbl[v].ch];
      end
      chk("tbl_handshake", int'(hs), 1);
      @(posedge clk);
      #1 bus.req_valid = '0;
      do begin
        @(negedge clk);
        lat++;
      end while (!bus.out_valid && lat < 10);
      chk("tbl_latency", lat, 3);
      chk("tbl_binary", int'(bus.out_binary), int'(tbl[v].bin));
      chk("tbl_ch", int'(bus.out_ch), int'(tbl[v].ch));
    end
    idle(6);

    // backpressure: credits stop at FIFO_DEPTH grants
    do_reset();
    bus.out_ready = 1'b0;
    h0 = hs_count;
    bus.req_valid = '1;
    idle(20);
    chk("t3_grants", hs_count - h0, DEPTH);
    @(negedge clk);
    chk("t3_ready_low", int'(bus.req_ready), 0);
    chk("t3_out_valid", int'(bus.out_valid), 1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    p0 = pop_count;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 40 && sb_q.size() != 0; k++) idle(1);
    chk("t3_drained", sb_q.size(), 0);
    chk("t3_pops", pop_count - p0, DEPTH);

    // reset with 2 in flight and 3 buffered
    idle(4);
    do_reset();
    bus.out_ready = 1'b0;
    h0 = hs_count;
    bus.req_valid = '1;
    for (int k = 0; k < 20 && hs_count - h0 < 5; k++) idle(1);
    chk("t4_grants", hs_count - h0, 5);
    rst = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    chk("t4_pre_valid", int'(bus.out_valid), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.req_valid = '1;
    @(negedge clk);
    chk("t4_out_valid", int'(bus.out_valid), 0);
    chk("t4_out_binary", int'(bus.out_binary), 0);
    chk("t4_out_ch", int'(bus.out_ch), 0);
    chk("t4_i_dv", int'(bus.g2b_i_dv), 0);
    chk("t4_g2b_gray", int'(bus.g2b_gray), 0);
    chk("t4_err_clear", int'(bus.sched_err), 0);
    chk("t4_grant_ch0", int'(bus.req_ready), 1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    chk("t4_late_err", int'(bus.sched_err), 1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    idle(8);
    chk("t4_drained", sb_q.size(), 0);
    chk("t4_err_sticky", int'(bus.sched_err), 1);

    // stray g2b_o_dv with nothing issued
    do_reset();
    idle(3);
    @(negedge clk);
    chk("t5_err_clear", int'(bus.sched_err), 0);
    @(posedge clk);
    #1 force_dv = 1'b1;
    @(posedge clk);
    #1 force_dv = 1'b0;
    @(negedge clk);
    chk("t5_err_set", int'(bus.sched_err), 1);
    chk("t5_no_write", int'(bus.out_valid), 0);
    idle(5);
    @(negedge clk);
    chk("t5_err_hold", int'(bus.sched_err), 1);
    chk("t5_still_empty", int'(bus.out_valid), 0);

    // random valid/ready traffic
    do_reset();
    h0 = hs_count;
    for (int c = 0; c < 10000; c++) begin
      bus.req_valid = NCH'($urandom);
      for (int i = 0; i < NCH; i++) bus.req_gray[i] = W'($urandom);
      bus.out_ready = 1'($urandom_range(1, 0));
      idle(1);
    end
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 60 && sb_q.size() != 0; k++) idle(1);
    chk("t6_drained", sb_q.size(), 0);
    chk("t6_activity", int'(hs_count - h0 > 2500), 1);
    chk("t6_no_err", int'(bus.sched_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
